// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader: FSM state encoding,
// word geometry and the endian-aware byte-lane selector.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_VERIFY,
        ST_DONE
    } state_t;

    localparam int unsigned WORD_BYTES = 4;

    // Byte at offset idx from the word base; big-endian places bits [31:24] at offset 0.
    function automatic logic [7:0] byte_select(input logic [31:0] i_word,
                                               input logic [1:0]  i_idx,
                                               input logic        i_big_endian);
        logic [1:0] lane;
        lane = i_big_endian ? (2'd3 - i_idx) : i_idx;
        return i_word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/imem_byte_sel.sv
// Byte-lane extractor: picks one byte of a 32-bit word by address offset,
// honouring the configured endianness.
module imem_byte_sel
    import imem_loader_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] i_word,
    input  logic [1:0]  i_idx,
    output logic [7:0]  o_byte
);

    assign o_byte = byte_select(i_word, i_idx, BIG_ENDIAN);

endmodule

// File: rtl/imem_loader.sv
// Program loader: takes 32-bit words on a valid/ready stream and writes them to
// byte-wide DRAM four bytes per word. Optional readback check: IMEM_LOADER_VERIFY_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned MAX_WORDS  = 1024,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             s_valid,
    input  logic [31:0]                      s_data,
    input  logic                             s_last,
    output logic                             s_ready,
    output logic [31:0]                      mem_addr,
    output logic [7:0]                       mem_wdata,
    output logic                             mem_we,
    input  logic [31:0]                      mem_rdata,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic [$clog2(MAX_WORDS+1)-1:0]   word_count
);

    localparam int unsigned WCW = $clog2(MAX_WORDS + 1);
    localparam logic [WCW-1:0] MAX_CNT = WCW'(MAX_WORDS);
    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    state_t           r_state;
    state_t           w_next;
    state_t           w_exit_state;
    logic [31:0]      r_word;
    logic             r_last;
    logic [1:0]       r_k;
    logic [WCW-1:0]   r_count;
    logic             r_err;

    logic             w_start_ok;
    logic             w_hs;
    logic             w_exit_eval;
    logic             w_full;
    logic [WCW-1:0]   w_count_inc;
    logic [WCW-1:0]   w_exit_count;
    logic [31:0]      w_word_base;
    logic [7:0]       w_byte;

    imem_byte_sel #(.BIG_ENDIAN(BIG_ENDIAN)) u_byte_sel (
        .i_word (r_word),
        .i_idx  (r_k),
        .o_byte (w_byte)
    );

    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_hs        = s_valid && (r_state == ST_ACCEPT);
    assign w_count_inc = r_count + WCW'(1);
    assign w_word_base = BASE_ADDR + (32'(WORD_BYTES) * 32'(r_count));

    // Exit is decided after the count update: in the final WRITE cycle using the
    // incremented value, or in VERIFY where the register already holds it.
`ifdef IMEM_LOADER_VERIFY_EN
    assign w_exit_eval  = (r_state == ST_VERIFY);
    assign w_exit_count = r_count;
`else
    assign w_exit_eval  = (r_state == ST_WRITE) && (r_k == LAST_BYTE);
    assign w_exit_count = w_count_inc;
    logic w_unused_rdata;
    assign w_unused_rdata = ^mem_rdata;
`endif

    assign w_full       = (w_exit_count == MAX_CNT);
    assign w_exit_state = (r_last || w_full) ? ST_DONE : ST_ACCEPT;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_next = ST_ACCEPT;
            ST_ACCEPT:        if (s_valid) w_next = ST_WRITE;
            ST_WRITE: begin
                if (r_k == LAST_BYTE) begin
`ifdef IMEM_LOADER_VERIFY_EN
                    w_next = ST_VERIFY;
`else
                    w_next = w_exit_state;
`endif
                end
            end
            ST_VERIFY:        w_next = w_exit_state;
            default:          w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_ACCEPT: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            ST_WRITE: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = w_word_base + 32'(r_k);
                mem_wdata = w_byte;
            end
            ST_VERIFY: begin
                busy     = 1'b1;
                mem_addr = w_word_base - 32'(WORD_BYTES);
            end
            ST_DONE:   done = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word  <= '0;
            r_last  <= 1'b0;
            r_k     <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_count <= '0;
                r_err   <= 1'b0;
            end
            if (w_hs) begin
                r_word <= s_data;
                r_last <= s_last;
                r_k    <= '0;
            end
            if (r_state == ST_WRITE) begin
                r_k <= r_k + 2'd1;
                if (r_k == LAST_BYTE) r_count <= w_count_inc;
            end
            if (w_exit_eval && !r_last && w_full) r_err <= 1'b1;
`ifdef IMEM_LOADER_VERIFY_EN
            if ((r_state == ST_VERIFY) && (mem_rdata != r_word)) r_err <= 1'b1;
`endif
        end
    end

    assign err        = r_err;
    assign word_count = r_count;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: two instances (big-endian/base 0 and
// little-endian/base 0x100 with MAX_WORDS=2), each backed by a byte-array DRAM model.
module tb_imem_loader;

`ifdef IMEM_LOADER_VERIFY_EN
    localparam int VLAT = 1;
`else
    localparam int VLAT = 0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start0, start1, s_valid, s_last;
    logic [31:0] s_data;

    logic        ready0, we0, busy0, done0, err0;
    logic [31:0] addr0, rdata0;
    logic [7:0]  wdata0;
    logic [10:0] wc0;

    logic        ready1, we1, busy1, done1, err1;
    logic [31:0] addr1, rdata1;
    logic [7:0]  wdata1;
    logic [1:0]  wc1;

    imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(1024), .BIG_ENDIAN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(ready0), .mem_addr(addr0), .mem_wdata(wdata0),
        .mem_we(we0), .mem_rdata(rdata0), .busy(busy0), .done(done0), .err(err0),
        .word_count(wc0));

    imem_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(2), .BIG_ENDIAN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(ready1), .mem_addr(addr1), .mem_wdata(wdata1),
        .mem_we(we1), .mem_rdata(rdata1), .busy(busy1), .done(done1), .err(err1),
        .word_count(wc1));

    // DRAM models; dut0 memory can corrupt one byte address on write
    logic [7:0]  dram0 [0:1023];
    logic [7:0]  dram1 [0:1023];
    logic        corrupt_en;
    logic [31:0] corrupt_addr;

    always @(posedge clk) begin
        if (we0) dram0[addr0[9:0]] <= (corrupt_en && addr0 == corrupt_addr) ? ~wdata0 : wdata0;
        if (we1) dram1[addr1[9:0]] <= wdata1;
    end

    always_comb begin
        rdata0 = {dram0[{addr0[9:2], 2'd0}], dram0[{addr0[9:2], 2'd1}],
                  dram0[{addr0[9:2], 2'd2}], dram0[{addr0[9:2], 2'd3}]};
        rdata1 = {dram1[{addr1[9:2], 2'd3}], dram1[{addr1[9:2], 2'd2}],
                  dram1[{addr1[9:2], 2'd1}], dram1[{addr1[9:2], 2'd0}]};
    end

    // Observation mux: sel picks which instance the stimulus tasks watch
    logic        sel;
    logic        o_ready, o_we;
    logic [31:0] o_addr;
    logic [7:0]  o_wdata;
    always_comb begin
        o_ready = sel ? ready1 : ready0;
        o_we    = sel ? we1    : we0;
        o_addr  = sel ? addr1  : addr0;
        o_wdata = sel ? wdata1 : wdata0;
    end

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int k, input bit be);
        int shift;
        shift = be ? 8 * (3 - k) : 8 * k;
        return 8'((w >> shift) & 32'hFF);
    endfunction

    task automatic pulse_start();
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of the fourth byte cycle.
    task automatic send_word(input logic [31:0] w, input logic last, input int gap, input int limit,
                             output logic [3:0][31:0] addrs, output logic [3:0][7:0] bytes,
                             output logic [3:0] wes, output int stray, output int waited,
                             output bit hs);
        stray = 0; waited = 0; hs = 0; addrs = '0; bytes = '0; wes = '0;
        s_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            if (o_we) stray++;
        end
        s_data = w; s_last = last; s_valid = 1'b1;
        while (!hs && waited < limit) begin
            if (o_ready) hs = 1;
            else begin
                @(negedge clk);
                waited++;
                if (o_we) stray++;
            end
        end
        if (!hs) begin
            s_valid = 1'b0; s_last = 1'b0;
            return;
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            addrs[k] = o_addr; bytes[k] = o_wdata; wes[k] = o_we;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ready0, we0, busy0, done0, err0} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags0 got %b want 00000", {ready0, we0, busy0, done0, err0});
        end
        n_checks++;
        if (addr0 !== 32'h0 || wdata0 !== 8'h0 || wc0 !== 11'd0) begin
            n_fail++; $display("FAIL reset_bus0 addr=%h wdata=%h wc=%0d want 0", addr0, wdata0, wc0);
        end
        n_checks++;
        if ({ready1, we1, busy1, done1, err1} !== 5'b0 || wc1 !== 2'd0 || addr1 !== 32'h0) begin
            n_fail++; $display("FAIL reset_dut1 flags=%b wc=%0d addr=%h want 0", {ready1, we1, busy1, done1, err1}, wc1, addr1);
        end
        rst = 1'b0;
        sel = 1'b0;
        pulse_start();
        n_checks++;
        if (ready0 !== 1'b1 || busy0 !== 1'b1 || done0 !== 1'b0) begin
            n_fail++; $display("FAIL start_response ready=%b busy=%b done=%b want 1 1 0", ready0, busy0, done0);
        end
    endtask

    task automatic test_single_word();
        logic [3:0][31:0] a; logic [3:0][7:0] b; logic [3:0] we;
        logic [7:0] exp [4];
        int stray, waited; bit hs;
        exp = '{8'h20, 8'h08, 8'h00, 8'h05};
        sel = 1'b0;
        do_reset();
        pulse_start();
        send_word(32'h2008_0005, 1'b1, 0, 20, a, b, we, stray, waited, hs);
        n_checks++;
        if (!hs) begin n_fail++; $display("FAIL single_handshake got 0 want 1"); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (a[k] !== 32'(k) || b[k] !== exp[k] || we[k] !== 1'b1) begin
                n_fail++; $display("FAIL single_byte%0d addr=%h data=%h we=%b want %h %h 1", k, a[k], b[k], we[k], k, exp[k]);
            end
        end
        repeat (1 + VLAT) @(negedge clk);
        n_checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || ready0 !== 1'b0 || err0 !== 1'b0) begin
            n_fail++; $display("FAIL single_done done=%b busy=%b ready=%b err=%b want 1 0 0 0", done0, busy0, ready0, err0);
        end
        n_checks++;
        if (wc0 !== 11'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", wc0); end
        n_checks++;
        if (rdata0 !== 32'h2008_0005) begin n_fail++; $display("FAIL single_fetch got %h want 20080005", rdata0); end
    endtask

    task automatic test_gaps();
        logic [3:0][31:0] a; logic [3:0][7:0] b; logic [3:0] we;
        logic [31:0] w;
        int stray, waited; bit hs;
        sel = 1'b0;
        do_reset();
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            send_word(w, i == 2, 2, 20, a, b, we, stray, waited, hs);
            n_checks++;
            if (!hs || stray != 0) begin
                n_fail++; $display("FAIL gap_word%0d hs=%0d stray_writes=%0d want 1 0", i, hs, stray);
            end
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (a[k] !== 32'(4 * i + k) || b[k] !== exp_byte(w, k, 1) || we[k] !== 1'b1) begin
                    n_fail++; $display("FAIL gap_word%0d_byte%0d addr=%h data=%h we=%b want %h %h 1", i, k, a[k], b[k], we[k], 4 * i + k, exp_byte(w, k, 1));
                end
            end
            // start while busy must not restart the session
            if (i == 0) pulse_start();
        end
        repeat (1 + VLAT) @(negedge clk);
        n_checks++;
        if (done0 !== 1'b1 || wc0 !== 11'd3 || err0 !== 1'b0) begin
            n_fail++; $display("FAIL gap_end done=%b wc=%0d err=%b want 1 3 0", done0, wc0, err0);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0][31:0] a; logic [3:0][7:0] b; logic [3:0] we;
        logic [31:0] words [6];
        int stray, waited; bit hs;
        sel = 1'b0;
        do_reset();
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            words[i] = $urandom;
            send_word(words[i], i == 5, 0, 20, a, b, we, stray, waited, hs);
            n_checks++;
            if (!hs || (i > 0 && waited != 1 + VLAT)) begin
                n_fail++; $display("FAIL b2b_rate%0d hs=%0d wait=%0d want 1 %0d", i, hs, waited, 1 + VLAT);
            end
            n_checks++;
            if (a[0] !== 32'(4 * i) || a[3] !== 32'(4 * i + 3) || we !== 4'b1111) begin
                n_fail++; $display("FAIL b2b_addr%0d first=%h last=%h we=%b want %h %h 1111", i, a[0], a[3], we, 4 * i, 4 * i + 3);
            end
        end
        repeat (1 + VLAT) @(negedge clk);
        n_checks++;
        if (done0 !== 1'b1 || wc0 !== 11'd6) begin
            n_fail++; $display("FAIL b2b_end done=%b wc=%0d want 1 6", done0, wc0);
        end
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (dram0[4 * i + k] !== exp_byte(words[i], k, 1)) begin
                    n_fail++; $display("FAIL b2b_dram[%0d] got %h want %h", 4 * i + k, dram0[4 * i + k], exp_byte(words[i], k, 1));
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [3:0][31:0] a; logic [3:0][7:0] b; logic [3:0] we;
        logic [31:0] w;
        int stray, waited; bit hs;
        sel = 1'b1;
        do_reset();
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            send_word(w, 1'b0, 0, 20, a, b, we, stray, waited, hs);
            n_checks++;
            if (hs !== (i < 2)) begin
                n_fail++; $display("FAIL ovf_handshake%0d got %0d want %0d", i, hs, i < 2);
            end
            if (i < 2) begin
                for (int k = 0; k < 4; k++) begin
                    n_checks++;
                    if (a[k] !== 32'h100 + 32'(4 * i + k) || b[k] !== exp_byte(w, k, 0)) begin
                        n_fail++; $display("FAIL ovf_word%0d_byte%0d addr=%h data=%h want %h %h", i, k, a[k], b[k], 32'h100 + 32'(4 * i + k), exp_byte(w, k, 0));
                    end
                end
            end
        end
        n_checks++;
        if (done1 !== 1'b1 || err1 !== 1'b1 || wc1 !== 2'd2 || busy1 !== 1'b0 || stray != 0) begin
            n_fail++; $display("FAIL ovf_end done=%b err=%b wc=%0d busy=%b stray=%0d want 1 1 2 0 0", done1, err1, wc1, busy1, stray);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_midwrite();
        logic [3:0][31:0] a; logic [3:0][7:0] b; logic [3:0] we;
        logic [31:0] w;
        logic [7:0] old3;
        int stray, waited; bit hs;
        sel = 1'b0;
        do_reset();
        pulse_start();
        old3 = dram0[3];
        w = {$urandom} & 32'hFFFF_FF00;
        w[7:0] = ~old3;
        s_data = w; s_last = 1'b0; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (we0 !== 1'b1 || addr0 !== 32'd2) begin
            n_fail++; $display("FAIL rstmid_byte2 we=%b addr=%h want 1 2", we0, addr0);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (we0 !== 1'b0 || busy0 !== 1'b0 || ready0 !== 1'b0 || wc0 !== 11'd0 || addr0 !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_idle we=%b busy=%b ready=%b wc=%0d addr=%h want 0", we0, busy0, ready0, wc0, addr0);
        end
        rst = 1'b0;
        n_checks++;
        if (dram0[2] !== exp_byte(w, 2, 1) || dram0[3] !== old3) begin
            n_fail++; $display("FAIL rstmid_dram b2=%h b3=%h want %h %h", dram0[2], dram0[3], exp_byte(w, 2, 1), old3);
        end
        pulse_start();
        w = $urandom;
        send_word(w, 1'b1, 0, 20, a, b, we, stray, waited, hs);
        repeat (1 + VLAT) @(negedge clk);
        n_checks++;
        if (!hs || a[0] !== 32'h0 || b[0] !== exp_byte(w, 0, 1) || wc0 !== 11'd1 || done0 !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_restart hs=%0d addr=%h data=%h wc=%0d done=%b want 1 0 %h 1 1", hs, a[0], b[0], wc0, done0, exp_byte(w, 0, 1));
        end
    endtask

`ifdef IMEM_LOADER_VERIFY_EN
    task automatic test_verify();
        logic [3:0][31:0] a; logic [3:0][7:0] b; logic [3:0] we;
        int stray, waited; bit hs;
        sel = 1'b0;
        do_reset();
        pulse_start();
        corrupt_addr = 32'd4;
        corrupt_en   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_word($urandom, i == 2, 0, 20, a, b, we, stray, waited, hs);
            @(negedge clk);
            n_checks++;
            if (we0 !== 1'b0 || addr0 !== 32'(4 * i)) begin
                n_fail++; $display("FAIL verify_cycle%0d we=%b addr=%h want 0 %h", i, we0, addr0, 4 * i);
            end
            @(negedge clk);
            n_checks++;
            if (err0 !== (i >= 1)) begin
                n_fail++; $display("FAIL verify_err%0d got %b want %0d", i, err0, i >= 1);
            end
        end
        n_checks++;
        if (done0 !== 1'b1 || wc0 !== 11'd3) begin
            n_fail++; $display("FAIL verify_end done=%b wc=%0d want 1 3", done0, wc0);
        end
        corrupt_en = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        s_data = '0; sel = 1'b0; corrupt_en = 1'b0; corrupt_addr = '0;
        for (int i = 0; i < 1024; i++) begin
            dram0[i] = 8'h00;
            dram1[i] = 8'h00;
        end
        test_reset();
        test_single_word();
        test_gaps();
        test_back_to_back();
        test_overflow();
        test_reset_midwrite();
`ifdef IMEM_LOADER_VERIFY_EN
        test_verify();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills instruction memory before the core runs: accepts 32-bit instruction words over a valid/ready stream, serialises each into four byte writes on the byte-wide DRAM write port (addr, 8-bit wdata, write_enable), and advances the load address. It is the write-side counterpart of the read-only instruction-memory path and sits between a boot source (testbench or UART front end) and the DRAM instance shared with the fetch path. The block reports busy/done and flags overflow and, optionally, readback mismatches.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of the first instruction word; must be 4-aligned.
- MAX_WORDS, 1024: capacity in words; loads beyond it are rejected.
- BIG_ENDIAN, 1: 1 = bits [31:24] at addr+0 (MIPS order); 0 = bits [7:0] at addr+0.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session at BASE_ADDR.
- s_valid  in  1  instruction word valid.
- s_data  in  32  instruction word.
- s_last  in  1  marks final word of the program; qualified by s_valid.
- s_ready  out  1  loader can accept a word this cycle.
- mem_addr  out  32  DRAM byte address.
- mem_wdata  out  8  DRAM write byte.
- mem_we  out  1  DRAM write enable.
- mem_rdata  in  32  DRAM read word at mem_addr (combinational read).
- busy  out  1  session in progress.
- done  out  1  session finished; held until next start or rst.
- err  out  1  sticky error (overflow or verify mismatch); cleared by start or rst.
- word_count  out  $clog2(MAX_WORDS+1)  words fully written this session.

## Operation
- States: IDLE, ACCEPT, WRITE, VERIFY (only with macro), DONE.
- IDLE: s_ready=0, mem_we=0. start -> ACCEPT; word_count<=0, err<=0, done<=0.
- ACCEPT: s_ready=1. On s_valid&s_ready latch s_data and s_last, byte index <=0 -> WRITE.
- WRITE: mem_we=1 for four consecutive cycles, byte index k=0..3, mem_addr=BASE_ADDR+4*word_count+k, mem_wdata per BIG_ENDIAN. After k=3: word_count+1; next state VERIFY if enabled, else evaluate exit.
- Exit evaluation: latched last -> DONE. Else word_count (post-increment) == MAX_WORDS -> DONE with err=1 (overflow, further words refused). Else -> ACCEPT.
- DONE: done=1, busy=0, s_ready=0; start -> new session (as from IDLE).
- start while busy is ignored. s_valid outside ACCEPT is ignored (no handshake).
- Address arithmetic: 32-bit, wrap modulo 2^32; no wrap detection.
- rst at any time: state IDLE, all outputs 0, word_count 0; bytes already written stay in DRAM.

## Timing
- Reset values: s_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, err 0, word_count 0.
- start at cycle T -> busy=1, s_ready=1 at T+1.
- Handshake at cycle H -> byte writes at H+1..H+4; s_ready low H+1..H+4 (H+1..H+5 with verify); s_ready high again at H+5 (H+6); throughput 1 word / 5 cycles (6).
- word_count increments at edge ending H+4.
- After last word: done=1 at H+5 (H+6 with verify).
- busy = state not IDLE/DONE.

## Configuration
- IMEM_LOADER_VERIFY_EN defined: VERIFY state after WRITE, one cycle; mem_we=0, mem_addr=word base address; compare mem_rdata to latched word; mismatch sets err (session continues). Adds one cycle per word.
- Undefined: no VERIFY state, mem_rdata unused, err only from overflow.

## Structure
- Shared package: state encoding typedef (IDLE/ACCEPT/WRITE/VERIFY/DONE), WORD_BYTES=4 constant, byte-select function for endianness.
- One sub-module natural: imem_byte_sel (32-bit word + 2-bit index + BIG_ENDIAN -> byte), reusable for byte-lane access elsewhere.

## Test plan
- rst high 2 cycles -> all outputs 0; start -> s_ready=1 next cycle, busy=1.
- Load 32'h2008_0005 (last) with BIG_ENDIAN=1, BASE_ADDR=0 -> writes 20,08,00,05 at addr 0..3 on four consecutive cycles; done=1, word_count=1; fetch read at addr 0 returns 32'h2008_0005.
- Three words with s_valid gaps of 2 cycles -> addresses 0,4,8 word bases; word_count=3; no writes during gaps.
- MAX_WORDS=2, send 3 words without s_last -> 2 words written, done=1, err=1, third word never handshaken.
- rst asserted during byte k=2 -> next cycle mem_we=0, state IDLE, word_count=0; subsequent start restarts at BASE_ADDR.
- With IMEM_LOADER_VERIFY_EN and a forced DRAM corruption on word 1 -> err=1 after its VERIFY cycle, load still completes with done=1.
